// File: rtl/gate_check_seq_if.sv
// Signal bundle between the gate-check sequencer (slave) and its controller/gate side (master).
interface gate_check_seq_if #(
    parameter int N_IN = 2
);
    logic            start;
    logic            abort;
    logic            dut_out;
    logic [N_IN-1:0] dut_in;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] fail_vec;

    modport master (
        output start, abort, dut_out,
        input  dut_in, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        input  start, abort, dut_out,
        output dut_in, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/gate_check_seq.sv
// Sweeps all input vectors of a combinational gate, samples its output after a
// settle time and compares against an expected truth table.
module gate_check_seq #(
    parameter int                   N_IN   = 2,
    parameter logic [2**N_IN-1:0]   EXP_TT = 4'b1000,
    parameter int                   SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    gate_check_seq_if.slave  gbus
);
    localparam int             CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]  CNT_INIT = CW'(SETTLE - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N_IN-1:0] dut_in_q, dut_in_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] fail_q, fail_d;
    logic            ff_q, ff_d;
    logic            mismatch;
    logic [N_IN:0]   err_next;

    // Default to mismatch so an X/Z gate output is counted as an error.
    always_comb begin
        mismatch = 1'b1;
        if (gbus.dut_out == EXP_TT[vec_q]) mismatch = 1'b0;
        err_next = err_q + (N_IN+1)'(mismatch);
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        dut_in_d = dut_in_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
        fail_d   = fail_q;
        ff_d     = ff_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (gbus.start) begin
                    state_d  = S_SETTLE;
                    vec_d    = '0;
                    cnt_d    = CNT_INIT;
                    dut_in_d = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    err_d    = '0;
                    fail_d   = '0;
                    ff_d     = 1'b0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) state_d = S_CHECK;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_CHECK: begin
                err_d = err_next;
                if (mismatch && !ff_q) begin
                    fail_d = vec_q;
                    ff_d   = 1'b1;
                end
                if (vec_q == '1) begin
                    state_d  = S_DONE;
                    dut_in_d = '0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    pass_d   = (err_next == '0);
                end else begin
                    state_d  = S_SETTLE;
                    vec_d    = vec_q + N_IN'(1);
                    dut_in_d = vec_q + N_IN'(1);
                    cnt_d    = CNT_INIT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides the CHECK update; partial err/fail results are kept.
        if ((state_q == S_SETTLE || state_q == S_CHECK) && gbus.abort) begin
            state_d  = S_IDLE;
            vec_d    = vec_q;
            cnt_d    = cnt_q;
            dut_in_d = '0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            pass_d   = 1'b0;
            err_d    = err_q;
            fail_d   = fail_q;
            ff_d     = ff_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            vec_q    <= '0;
            cnt_q    <= '0;
            dut_in_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            fail_q   <= '0;
            ff_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            cnt_q    <= cnt_d;
            dut_in_q <= dut_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
            ff_q     <= ff_d;
        end
    end

    assign gbus.dut_in    = dut_in_q;
    assign gbus.busy      = busy_q;
    assign gbus.done      = done_q;
    assign gbus.pass      = pass_q;
    assign gbus.err_count = err_q;
    assign gbus.fail_vec  = fail_q;
endmodule

// File: tb/tb_gate_check_seq.sv
// Directed bench: three sequencer instances (2-in AND, 2-in XOR, 3-in AND with SETTLE=1).
module tb_gate_check_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   mode_a = 0;   // 0: real AND gate, 1: output tied 0, 2: output tied 1
    int   n;

    always #5 clk = ~clk;

    gate_check_seq_if #(.N_IN(2)) ifa ();
    gate_check_seq_if #(.N_IN(2)) ifb ();
    gate_check_seq_if #(.N_IN(3)) ifc ();

    assign ifa.dut_out = (mode_a == 0) ? (&ifa.dut_in) : (mode_a == 2);
    assign ifb.dut_out = ^ifb.dut_in;
    assign ifc.dut_out = &ifc.dut_in;

    gate_check_seq #(.N_IN(2), .EXP_TT(4'b1000), .SETTLE(2)) u_and2 (
        .clk(clk), .rst_n(rst_n), .gbus(ifa));
    gate_check_seq #(.N_IN(2), .EXP_TT(4'b0110), .SETTLE(2)) u_xor2 (
        .clk(clk), .rst_n(rst_n), .gbus(ifb));
    gate_check_seq #(.N_IN(3), .EXP_TT(8'h80), .SETTLE(1)) u_and3 (
        .clk(clk), .rst_n(rst_n), .gbus(ifc));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int which, input logic v);
        case (which)
            0:       ifa.start = v;
            1:       ifb.start = v;
            default: ifc.start = v;
        endcase
    endtask

    function automatic logic done_of(input int which);
        case (which)
            0:       return ifa.done;
            1:       return ifb.done;
            default: return ifc.done;
        endcase
    endfunction

    // Pulse start for one edge (edge 0 of the sweep).
    task automatic kick(input int which);
        set_start(which, 1'b1);
        tick();
        set_start(which, 1'b0);
    endtask

    // Edges counted until done rises, bounded by limit.
    task automatic wait_done(input int which, input int limit, output int edges);
        edges = 0;
        do begin
            tick();
            edges++;
        end while (!done_of(which) && edges < limit);
    endtask

    initial begin
        ifa.start = 1'b0; ifa.abort = 1'b0;
        ifb.start = 1'b0; ifb.abort = 1'b0;
        ifc.start = 1'b0; ifc.abort = 1'b0;
        tick();
        tick();
        check("rst_dut_in", ifa.dut_in, 0);
        check("rst_busy",   ifa.busy, 0);
        check("rst_done",   ifa.done, 0);
        check("rst_err",    ifa.err_count, 0);
        #3 rst_n = 1'b1;
        tick();

        // 1: real AND gate, vector stepping every 3 edges
        mode_a = 0;
        kick(0);
        for (int k = 0; k < 12; k++) begin
            check($sformatf("t1_dut_in_e%0d", k), ifa.dut_in, k / 3);
            check($sformatf("t1_busy_e%0d", k), ifa.busy, 1);
            tick();
        end
        check("t1_done",   ifa.done, 1);
        check("t1_pass",   ifa.pass, 1);
        check("t1_err",    ifa.err_count, 0);
        check("t1_fail",   ifa.fail_vec, 0);
        check("t1_dut_in", ifa.dut_in, 0);
        check("t1_busy",   ifa.busy, 0);
        ifa.abort = 1'b1;
        tick(); tick();
        ifa.abort = 1'b0;
        check("t1_done_held", ifa.done, 1);
        check("t1_pass_held", ifa.pass, 1);

        // 2: output tied 0
        mode_a = 1;
        kick(0);
        check("t2_done_clr", ifa.done, 0);
        wait_done(0, 40, n);
        check("t2_edges", n, 12);
        check("t2_pass",  ifa.pass, 0);
        check("t2_err",   ifa.err_count, 1);
        check("t2_fail",  ifa.fail_vec, 3);

        // 3: output tied 1, then real gates
        mode_a = 2;
        kick(0);
        wait_done(0, 40, n);
        check("t3_edges", n, 12);
        check("t3_pass",  ifa.pass, 0);
        check("t3_err",   ifa.err_count, 3);
        check("t3_fail",  ifa.fail_vec, 0);
        mode_a = 0;
        kick(0);
        check("t3_err_clr",  ifa.err_count, 0);
        check("t3_done_clr", ifa.done, 0);
        wait_done(0, 40, n);
        check("t3_and_pass", ifa.pass, 1);
        kick(1);
        wait_done(1, 40, n);
        check("t3_xor_edges", n, 12);
        check("t3_xor_pass",  ifb.pass, 1);
        check("t3_xor_err",   ifb.err_count, 0);

        // 4: abort during vector 2 settle, keeping partial errors
        mode_a = 2;
        kick(0);
        repeat (6) tick();
        check("t4_pre_vec", ifa.dut_in, 2);
        ifa.abort = 1'b1;
        tick();
        ifa.abort = 1'b0;
        check("t4_busy",   ifa.busy, 0);
        check("t4_done",   ifa.done, 0);
        check("t4_dut_in", ifa.dut_in, 0);
        check("t4_err",    ifa.err_count, 2);
        tick(); tick();
        check("t4_idle", ifa.busy, 0);
        // abort in the final CHECK beats the DONE transition and its error count
        mode_a = 1;
        kick(0);
        repeat (11) tick();
        check("t4_chk_vec", ifa.dut_in, 3);
        ifa.abort = 1'b1;
        tick();
        ifa.abort = 1'b0;
        check("t4_chk_done", ifa.done, 0);
        check("t4_chk_err",  ifa.err_count, 0);
        check("t4_chk_busy", ifa.busy, 0);
        mode_a = 0;
        kick(0);
        check("t4_restart_vec", ifa.dut_in, 0);
        wait_done(0, 40, n);
        check("t4_edges", n, 12);
        check("t4_pass",  ifa.pass, 1);

        // 5: async reset mid-CHECK, then start pulses while busy
        mode_a = 2;
        kick(0);
        repeat (5) tick();
        check("t5_pre_err", ifa.err_count, 1);
        check("t5_pre_vec", ifa.dut_in, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_dut_in", ifa.dut_in, 0);
        check("t5_rst_err",    ifa.err_count, 0);
        check("t5_rst_busy",   ifa.busy, 0);
        #2 rst_n = 1'b1;
        tick();
        mode_a = 0;
        kick(0);
        ifa.start = 1'b1;
        tick(); tick();
        ifa.start = 1'b0;
        wait_done(0, 40, n);
        check("t5_edges", n + 2, 12);
        check("t5_pass",  ifa.pass, 1);

        // 6: 3-input AND, SETTLE=1
        kick(2);
        check("t6_vec0", ifc.dut_in, 0);
        tick(); tick();
        check("t6_vec1", ifc.dut_in, 1);
        wait_done(2, 60, n);
        check("t6_edges", n + 2, 16);
        check("t6_pass",  ifc.pass, 1);
        check("t6_err",   ifc.err_count, 0);
        check("t6_dut_in", ifc.dut_in, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gate_check_seq.md
Name: gate_check_seq

Overview:
Self-checking sequencer for a combinational logic-gate under test (AND/OR/XOR/NAND etc. from the logic-gates library). On start it drives every input combination 0..2^N_IN-1 in ascending order onto the gate. It waits a programmable settle time, samples the gate output and compares it against a parameterised expected truth table. It accumulates a mismatch count and the first failing vector, then reports done/pass. It replaces hand-written per-gate stimulus sequences in lab benches and in the on-board self-test.

Parameters:
N_IN, 2, number of gate inputs (1..4)
EXP_TT, 4'b1000, expected truth table, width 2^N_IN; bit k = expected output for input vector k (default = 2-input AND)
SETTLE, 2, cycles the vector is held before sampling (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a sweep; sampled only in IDLE or DONE
abort  in  1  cancel a running sweep
dut_out  in  1  output of gate under test
dut_in  out  N_IN  input vector driven to gate; bit 0 = LSB input (e.g. b), bit 1 = a
busy  out  1  sweep in progress (SETTLE or CHECK)
done  out  1  sweep completed; held until next start
pass  out  1  valid with done: 1 iff err_count==0
err_count  out  N_IN+1  number of mismatching vectors in last sweep
fail_vec  out  N_IN  first mismatching vector; 0 if none

Behaviour:
- Reset (rst_n=0, async, any state): state=IDLE; dut_in=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0; internal vec=0, settle counter=0, first-fail flag=0.
- All outputs registered; state is one of IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE + start=1: dut_in<=0, vec<=0, cnt<=SETTLE-1, err_count<=0, fail_vec<=0, done<=0, pass<=0, first-fail flag cleared; ->SETTLE.
- IDLE/DONE + start=0: hold; done/pass/err_count/fail_vec retain last result.
- SETTLE: busy=1; cnt decrements each cycle; when cnt==0 ->CHECK. Lasts exactly SETTLE cycles.
- CHECK (one cycle): busy=1; compare dut_out with EXP_TT[vec]. Mismatch (including X/Z on dut_out) increments err_count. If it is the first mismatch, fail_vec<=vec and the flag is set.
  - vec==2^N_IN-1: ->DONE with done<=1 and pass<=(final err_count==0, including this cycle's result); dut_in<=0.
  - otherwise: vec<=vec+1, dut_in<=vec+1, cnt<=SETTLE-1; ->SETTLE.
- Timing: each vector occupies SETTLE+1 cycles. done rises on the 2^N_IN*(SETTLE+1)-th rising edge after the edge that samples start. Default: 12 edges.
- start while busy: ignored.
- abort=1 in SETTLE/CHECK: ->IDLE next edge; dut_in<=0, busy<=0, done<=0, pass<=0; err_count/fail_vec keep partial values. abort has priority over the CHECK transition. abort in IDLE/DONE: no effect; start wins if both are asserted.
- err_count cannot overflow (max 2^N_IN fits in N_IN+1 bits).
- dut_in changes only on clock edges, so the gate sees a stable vector for the full SETTLE+1 cycles.

Test Plan:
1. Real AND gate, defaults, start pulse -> dut_in steps 0,1,2,3 every 3 cycles; done=1 at edge 12; pass=1, err_count=0, fail_vec=0; dut_in returns to 0.
2. dut_out tied 0, EXP_TT=4'b1000 -> done at edge 12, pass=0, err_count=1, fail_vec=3.
3. dut_out tied 1 -> err_count=3, fail_vec=0, pass=0; then XOR gate with EXP_TT=4'b0110 and a new start -> counters cleared, pass=1.
4. abort asserted during vector 2 SETTLE -> IDLE next edge, busy=0, done=0, dut_in=0; a later start runs a full sweep from vector 0.
5. rst_n pulled low mid-CHECK, asynchronously between edges -> all outputs 0 immediately. start pulses during busy -> ignored; sweep length unchanged (12 edges).
6. SETTLE=1, N_IN=3, EXP_TT=8'h80 with 3-input AND -> 8 vectors, done at edge 16, pass=1.
